// File: rtl/dc_mem_responder.sv
// dc_mem_responder: pipelined word-read responder backed by a word store, with a
// forwarding writeback line buffer that drains into the store when reads leave it idle.
module dc_mem_responder #(
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 2,
  parameter int WB_DEPTH     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         is_request,
  input  logic [31:0]  request_addr,
  output logic [31:0]  requested_data,
  output logic         data_valid,
  input  logic         is_wb,
  input  logic [31:0]  wb_addr,
  input  logic [255:0] wb_data,
  output logic         wb_full,
  output logic         wb_overflow,
  output logic         busy
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = WB_DEPTH > 1 ? $clog2(WB_DEPTH) : 1;
  localparam int CW = $clog2(WB_DEPTH + 1);
  typedef enum logic {IDLE, DRAIN} state_e;
  logic [31:0]   mem_q  [MEM_WORDS];
  logic [26:0]   tag_q  [WB_DEPTH];
  logic [255:0]  line_q [WB_DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, k;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    ctr_q, ctr_d;
  state_e        state_q, state_d;
  logic          ovf_q;
  logic          vld_q [READ_LATENCY];
  logic [31:0]   dat_q [READ_LATENCY];
  logic          push, pop, drain_we, hit, any_vld;
  logic [31:0]   fwd_data, rd_data;
  logic [29:0]   wr_word;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (int'(p) == WB_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Walk entries oldest to youngest so the youngest matching line wins
  always_comb begin
    hit = 1'b0;
    fwd_data = '0;
    k = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      k = PW'((int'(head_q) + i) % WB_DEPTH);
      if (i < int'(count_q) && tag_q[k] == request_addr[31:5]) begin
        hit = 1'b1;
        fwd_data = line_q[k][32*request_addr[4:2] +: 32];
      end
    end
    rd_data = hit ? fwd_data : mem_q[request_addr[AW+1:2]];
  end

  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < READ_LATENCY; i++) any_vld = any_vld | vld_q[i];
  end

  assign wb_full        = count_q == CW'(WB_DEPTH);
  assign push           = is_wb && !wb_full;
  assign wr_word        = {tag_q[head_q], ctr_q};
  assign busy           = (count_q != '0) | any_vld;
  assign wb_overflow    = ovf_q;
  assign data_valid     = vld_q[READ_LATENCY-1];
  assign requested_data = dat_q[READ_LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ctr_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      ctr_q    <= ctr_d;
      ovf_q    <= ovf_q | (is_wb && wb_full);
      vld_q[0] <= is_request;
      dat_q[0] <= is_request ? rd_data : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  // Storage arrays carry no reset; the store must survive reset
  always_ff @(posedge clk) begin
    if (drain_we) mem_q[wr_word[AW-1:0]] <= line_q[head_q][32*ctr_q +: 32];
    if (push) begin
      tag_q[tail_q]  <= wb_addr[31:5];
      line_q[tail_q] <= wb_data;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && count_q != '0) state_d = DRAIN;
    if (state_q == DRAIN && pop && count_d == '0) state_d = IDLE;
  end

  always_comb begin
    drain_we = state_q == DRAIN && !is_request && !reset;
    pop      = drain_we && ctr_q == 3'd7;
    ctr_d    = state_q == IDLE ? 3'd0 : drain_we ? ctr_q + 3'd1 : ctr_q;
    head_d   = pop ? inc(head_q) : head_q;
    tail_d   = push ? inc(tail_q) : tail_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end
endmodule

// File: tb/tb_dc_mem_responder.sv
// tb_dc_mem_responder: directed self-checking bench for dc_mem_responder
module tb_dc_mem_responder;
  logic         clk = 1'b0, reset, is_request, is_wb;
  logic [31:0]  request_addr, wb_addr, requested_data;
  logic [255:0] wb_data;
  logic         data_valid, wb_full, wb_overflow, busy;
  int checks = 0, passed = 0;

  dc_mem_responder dut (
    .clk(clk), .reset(reset), .is_request(is_request), .request_addr(request_addr),
    .requested_data(requested_data), .data_valid(data_valid), .is_wb(is_wb),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_full(wb_full),
    .wb_overflow(wb_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [31:0] a, input logic [31:0] base);
    is_wb = 1'b1;
    wb_addr = a;
    for (int j = 0; j < 8; j++) wb_data[32*j +: 32] = base + 32'(j);
    step();
    is_wb = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    checks++; if (busy !== 1'b0) $display("FAIL %s_drain busy=%0b want 0", name, busy); else passed++;
  endtask

  task automatic do_read(input logic [31:0] a, output logic v, output logic [31:0] d);
    is_request = 1'b1;
    request_addr = a;
    step();
    is_request = 1'b0;
    step();
    v = data_valid;
    d = requested_data;
  endtask

  task automatic test_reset();
    reset = 1'b1; is_request = 1'b0; is_wb = 1'b0; request_addr = '0; wb_addr = '0; wb_data = '0;
    step(); step();
    reset = 1'b0;
    checks++; if (data_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", data_valid); else passed++;
    checks++; if (requested_data !== 32'h0) $display("FAIL rst_data got %h want 0", requested_data); else passed++;
    checks++; if (wb_full !== 1'b0) $display("FAIL rst_full got %0b want 0", wb_full); else passed++;
    checks++; if (wb_overflow !== 1'b0) $display("FAIL rst_ovf got %0b want 0", wb_overflow); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy); else passed++;
  endtask

  task automatic test_single_read();
    push_line(32'h40, 32'hA5A5_0001);
    wait_idle("single");
    is_request = 1'b1; request_addr = 32'h40;
    step();
    is_request = 1'b0;
    checks++; if (data_valid !== 1'b0) $display("FAIL single_early got %0b want 0", data_valid); else passed++;
    step();
    checks++; if (data_valid !== 1'b1) $display("FAIL single_valid got %0b want 1", data_valid); else passed++;
    checks++; if (requested_data !== 32'hA5A5_0001) $display("FAIL single_data got %h want a5a50001", requested_data); else passed++;
    step();
    checks++; if (data_valid !== 1'b0) $display("FAIL single_after got %0b want 0", data_valid); else passed++;
    checks++; if (requested_data !== 32'h0) $display("FAIL single_zero got %h want 0", requested_data); else passed++;
  endtask

  task automatic test_back_to_back();
    logic       ev;
    logic [31:0] ed;
    push_line(32'h80, 32'hB000_0000);
    wait_idle("b2b");
    for (int c = 0; c < 10; c++) begin
      is_request = c < 8;
      request_addr = 32'h80 + 32'(4 * c);
      step();
      ev = c >= 1 && c <= 8;
      ed = ev ? 32'hB000_0000 + 32'(c - 1) : 32'h0;
      checks++; if (data_valid !== ev) $display("FAIL b2b_valid cyc%0d got %0b want %0b", c, data_valid, ev); else passed++;
      checks++; if (requested_data !== ed) $display("FAIL b2b_data cyc%0d got %h want %h", c, requested_data, ed); else passed++;
    end
    is_request = 1'b0;
  endtask

  task automatic test_forward();
    logic        v;
    logic [31:0] d;
    push_line(32'h100, 32'h1);
    checks++; if (busy !== 1'b1) $display("FAIL fwd_busy got %0b want 1", busy); else passed++;
    do_read(32'h10C, v, d);
    checks++; if (v !== 1'b1) $display("FAIL fwd_valid got %0b want 1", v); else passed++;
    checks++; if (d !== 32'h4) $display("FAIL fwd_data got %h want 4", d); else passed++;
    wait_idle("fwd");
    for (int j = 0; j < 8; j++) begin
      do_read(32'h100 + 32'(4 * j), v, d);
      checks++; if (d !== 32'(j + 1)) $display("FAIL fwd_store w%0d got %h want %h", j, d, 32'(j + 1)); else passed++;
    end
  endtask

  task automatic test_overflow();
    logic        v;
    logic [31:0] d;
    is_request = 1'b1; request_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      push_line(i < 4 ? 32'h1000 + 32'(32 * i) : 32'h40, i < 4 ? 32'hF000_0000 + 32'(256 * i) : 32'h1234_5678);
      checks++; if (wb_full !== (i >= 3)) $display("FAIL ovf_full push%0d got %0b want %0b", i, wb_full, i >= 3); else passed++;
      checks++; if (wb_overflow !== (i == 4)) $display("FAIL ovf_flag push%0d got %0b want %0b", i, wb_overflow, i == 4); else passed++;
    end
    is_request = 1'b0;
    wait_idle("ovf");
    checks++; if (wb_overflow !== 1'b1) $display("FAIL ovf_sticky got %0b want 1", wb_overflow); else passed++;
    checks++; if (wb_full !== 1'b0) $display("FAIL ovf_unfull got %0b want 0", wb_full); else passed++;
    do_read(32'h40, v, d);
    checks++; if (d !== 32'hA5A5_0001) $display("FAIL ovf_dropped got %h want a5a50001", d); else passed++;
    do_read(32'h1060, v, d);
    checks++; if (d !== 32'hF000_0300) $display("FAIL ovf_line3 got %h want f0000300", d); else passed++;
  endtask

  task automatic test_same_line();
    logic        v;
    logic [31:0] d;
    push_line(32'h200, 32'hC000_0000);
    push_line(32'h200, 32'hD000_0000);
    do_read(32'h200, v, d);
    checks++; if (v !== 1'b1) $display("FAIL same_valid got %0b want 1", v); else passed++;
    checks++; if (d !== 32'hD000_0000) $display("FAIL same_fwd0 got %h want d0000000", d); else passed++;
    do_read(32'h214, v, d);
    checks++; if (d !== 32'hD000_0005) $display("FAIL same_fwd5 got %h want d0000005", d); else passed++;
    wait_idle("same");
    do_read(32'h200, v, d);
    checks++; if (d !== 32'hD000_0000) $display("FAIL same_store0 got %h want d0000000", d); else passed++;
    do_read(32'h21C, v, d);
    checks++; if (d !== 32'hD000_0007) $display("FAIL same_store7 got %h want d0000007", d); else passed++;
  endtask

  task automatic test_reset_mid();
    logic        v;
    logic [31:0] d;
    push_line(32'h300, 32'hE000_0000);
    for (int i = 0; i < 4; i++) step();
    is_request = 1'b1; request_addr = 32'h40;
    step();
    is_request = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (data_valid !== 1'b0) $display("FAIL mid_valid got %0b want 0", data_valid); else passed++;
    checks++; if (requested_data !== 32'h0) $display("FAIL mid_data got %h want 0", requested_data); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_busy got %0b want 0", busy); else passed++;
    checks++; if (wb_full !== 1'b0) $display("FAIL mid_full got %0b want 0", wb_full); else passed++;
    checks++; if (wb_overflow !== 1'b0) $display("FAIL mid_ovf got %0b want 0", wb_overflow); else passed++;
    step();
    checks++; if (data_valid !== 1'b0) $display("FAIL mid_discard got %0b want 0", data_valid); else passed++;
    do_read(32'h300, v, d);
    checks++; if (d !== 32'hE000_0000) $display("FAIL mid_kept0 got %h want e0000000", d); else passed++;
    do_read(32'h304, v, d);
    checks++; if (d !== 32'hE000_0001) $display("FAIL mid_kept1 got %h want e0000001", d); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_forward();
    test_overflow();
    test_same_line();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
